// File: rtl/apb_rr_arbiter.sv
// Round-robin APB arbiter and slave decoder with per-transfer timeout watchdog.
// Shares one APB bus among MASTERS cluster ports and routes each granted transfer
// to one of SLAVES targets selected by the top address bits.
module apb_rr_arbiter #(
  parameter int unsigned MASTERS    = 4,
  parameter int unsigned SLAVES     = 2,
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [MASTERS*BUS_WIDTH-1:0]     S_PADDR,
  input  logic [MASTERS-1:0]               S_PWRITE,
  input  logic [MASTERS-1:0]               S_PSELx,
  input  logic [MASTERS-1:0]               S_PENABLE,
  input  logic [MASTERS*DATA_WIDTH-1:0]    S_PWDATA,
  output logic [MASTERS*DATA_WIDTH-1:0]    S_PRDATA,
  output logic [MASTERS-1:0]               S_PREADY,
  output logic [BUS_WIDTH-1:0]             M_PADDR,
  output logic                             M_PWRITE,
  output logic                             M_PENABLE,
  output logic [DATA_WIDTH-1:0]            M_PWDATA,
  output logic [SLAVES-1:0]                M_PSELx,
  input  logic [SLAVES*DATA_WIDTH-1:0]     M_PRDATA,
  input  logic [SLAVES-1:0]                M_PREADY,
  output logic [MASTERS-1:0]               grant,
  output logic                             bus_timeout
);

  localparam int unsigned MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int unsigned SB = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_next;
  logic [MW-1:0] gnt_idx, gnt_idx_next;
  logic [SB-1:0] slv_idx, slv_idx_next;
  logic [MW-1:0] rr_ptr, rr_ptr_next;
  logic [CW-1:0] tmo_cnt, tmo_cnt_next;

  logic          req_found;
  logic [MW-1:0] scan_idx;
  logic [MW-1:0] win;
  logic [SB-1:0] win_sidx;
  logic          sel_held;
  logic          dec_err;
  logic          pready_s;
  logic          timeout_hit;
  logic          done;

  // Phases come from the FSM, so the masters' own enables carry no information.
  logic unused_penable;
  assign unused_penable = ^S_PENABLE;

  // Pick the first requester at or after the RR pointer and decode its target slave.
  always_comb begin
    req_found = 1'b0;
    win       = '0;
    scan_idx  = '0;
    win_sidx  = '0;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      scan_idx = MW'((32'(rr_ptr) + 32'(i)) % MASTERS);
      if (S_PSELx[scan_idx]) begin
        req_found = 1'b1;
        win       = scan_idx;
      end
    end
    if (SLAVES > 1) begin
      win_sidx = S_PADDR[32'(win)*BUS_WIDTH + BUS_WIDTH - SB +: SB];
    end
  end

  // Transfer status of the current owner; withdrawal overrides every completion.
  always_comb begin
    sel_held    = S_PSELx[gnt_idx];
    dec_err     = (32'(slv_idx) >= SLAVES);
    pready_s    = !dec_err && M_PREADY[slv_idx];
    timeout_hit = !dec_err && !pready_s && (tmo_cnt == CW'(TIMEOUT - 1));
    done        = (state == ACCESS) && sel_held && (dec_err || pready_s || timeout_hit);
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt_idx <= '0;
      slv_idx <= '0;
      rr_ptr  <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_next;
      gnt_idx <= gnt_idx_next;
      slv_idx <= slv_idx_next;
      rr_ptr  <= rr_ptr_next;
      tmo_cnt <= tmo_cnt_next;
    end
  end

  // Next-state: arbitrate in IDLE, fixed SETUP->ACCESS, leave ACCESS on done or withdrawal.
  always_comb begin
    state_next   = state;
    gnt_idx_next = gnt_idx;
    slv_idx_next = slv_idx;
    rr_ptr_next  = rr_ptr;
    tmo_cnt_next = tmo_cnt;
    case (state)
      IDLE: begin
        if (req_found) begin
          state_next   = SETUP;
          gnt_idx_next = win;
          slv_idx_next = win_sidx;
          rr_ptr_next  = MW'((32'(win) + 32'd1) % MASTERS);
        end
      end
      SETUP: begin
        if (!sel_held) begin
          state_next = IDLE;
        end else begin
          state_next   = ACCESS;
          tmo_cnt_next = '0;
        end
      end
      ACCESS: begin
        if (!sel_held || done) begin
          state_next = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus muxing and completion signalling; everything is forced low while reset is held.
  always_comb begin
    S_PRDATA    = '0;
    S_PREADY    = '0;
    M_PADDR     = '0;
    M_PWRITE    = 1'b0;
    M_PENABLE   = 1'b0;
    M_PWDATA    = '0;
    M_PSELx     = '0;
    grant       = '0;
    bus_timeout = 1'b0;
    if (!reset && (state == SETUP || state == ACCESS)) begin
      grant[gnt_idx] = 1'b1;
      M_PADDR        = S_PADDR[32'(gnt_idx)*BUS_WIDTH +: BUS_WIDTH];
      M_PWRITE       = S_PWRITE[gnt_idx];
      M_PWDATA       = S_PWDATA[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      if (!dec_err) begin
        M_PSELx[slv_idx] = 1'b1;
      end
      if (state == ACCESS) begin
        M_PENABLE = 1'b1;
        if (done) begin
          S_PREADY[gnt_idx] = 1'b1;
          bus_timeout       = timeout_hit;
          if (pready_s) begin
            S_PRDATA[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] =
              M_PRDATA[32'(slv_idx)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: a 2-slave instance with TIMEOUT=4 and a
// 3-slave instance used for the out-of-range decode case.
module tb_apb_rr_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // Main instance: MASTERS=4, SLAVES=2, TIMEOUT=4
  logic [63:0] s_paddr, s_pwdata;
  logic [3:0]  s_pwrite, s_psel, s_penable;
  logic [63:0] s_prdata;
  logic [3:0]  s_pready;
  logic [15:0] m_paddr, m_pwdata;
  logic        m_pwrite, m_penable;
  logic [1:0]  m_psel;
  logic [31:0] m_prdata;
  logic [1:0]  m_pready;
  logic [3:0]  grant;
  logic        bus_timeout;

  // Decode-error instance: MASTERS=4, SLAVES=3, TIMEOUT=4
  logic [63:0] d_paddr, d_pwdata;
  logic [3:0]  d_pwrite, d_psel, d_penable;
  logic [63:0] d_prdata;
  logic [3:0]  d_pready;
  logic [15:0] d_m_paddr, d_m_pwdata;
  logic        d_m_pwrite, d_m_penable;
  logic [2:0]  d_m_psel;
  logic [47:0] d_m_prdata;
  logic [2:0]  d_m_pready;
  logic [3:0]  d_grant;
  logic        d_bus_timeout;

  // Slave model for the main instance: per-slave wait states and a stuck-low switch
  int   wait_cfg [2];
  logic stuck    [2];
  int   acc_cnt  [2];

  apb_rr_arbiter #(.MASTERS(4), .SLAVES(2), .BUS_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(s_paddr), .S_PWRITE(s_pwrite), .S_PSELx(s_psel), .S_PENABLE(s_penable),
    .S_PWDATA(s_pwdata), .S_PRDATA(s_prdata), .S_PREADY(s_pready),
    .M_PADDR(m_paddr), .M_PWRITE(m_pwrite), .M_PENABLE(m_penable), .M_PWDATA(m_pwdata),
    .M_PSELx(m_psel), .M_PRDATA(m_prdata), .M_PREADY(m_pready),
    .grant(grant), .bus_timeout(bus_timeout)
  );

  apb_rr_arbiter #(.MASTERS(4), .SLAVES(3), .BUS_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(4)) dut3 (
    .clk(clk), .reset(reset),
    .S_PADDR(d_paddr), .S_PWRITE(d_pwrite), .S_PSELx(d_psel), .S_PENABLE(d_penable),
    .S_PWDATA(d_pwdata), .S_PRDATA(d_prdata), .S_PREADY(d_pready),
    .M_PADDR(d_m_paddr), .M_PWRITE(d_m_pwrite), .M_PENABLE(d_m_penable), .M_PWDATA(d_m_pwdata),
    .M_PSELx(d_m_psel), .M_PRDATA(d_m_prdata), .M_PREADY(d_m_pready),
    .grant(d_grant), .bus_timeout(d_bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_prdata   = {16'h5A5A, 16'h1234};
  assign d_m_prdata = 48'h3333_2222_1111;
  assign d_m_pready = 3'b111;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      m_pready[s] = m_psel[s] && m_penable && !stuck[s] && (acc_cnt[s] >= wait_cfg[s]);
    end
  end

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (m_psel[s] && m_penable && !m_pready[s]) acc_cnt[s] <= acc_cnt[s] + 1;
      else acc_cnt[s] <= 0;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input int m, input logic [15:0] addr, input logic wr, input logic [15:0] data);
    s_paddr[m*16 +: 16]  = addr;
    s_pwdata[m*16 +: 16] = data;
    s_pwrite[m]          = wr;
    s_psel[m]            = 1'b1;
  endtask

  task automatic drop(input int m);
    s_psel[m] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%h exp=0", grant); end
    checks++; if (m_psel !== 2'b0 || m_penable !== 1'b0) begin failures++; $display("FAIL reset_msel got=%b/%b exp=0/0", m_psel, m_penable); end
    checks++; if (m_paddr !== 16'h0 || m_pwdata !== 16'h0 || m_pwrite !== 1'b0) begin failures++; $display("FAIL reset_mbus got=%h/%h/%b exp=0", m_paddr, m_pwdata, m_pwrite); end
    checks++; if (s_pready !== 4'b0 || s_prdata !== 64'h0) begin failures++; $display("FAIL reset_sresp got=%h/%h exp=0", s_pready, s_prdata); end
    checks++; if (bus_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", bus_timeout); end
    checks++; if (d_grant !== 4'b0 || d_m_psel !== 3'b0) begin failures++; $display("FAIL reset_dut3 got=%h/%b exp=0", d_grant, d_m_psel); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    req(2, 16'h0010, 1'b0, 16'h0);
    step();
    checks++; if (m_psel !== 2'b01 || m_penable !== 1'b0) begin failures++; $display("FAIL read_setup got=%b/%b exp=01/0", m_psel, m_penable); end
    checks++; if (grant !== 4'b0100 || m_paddr !== 16'h0010) begin failures++; $display("FAIL read_setup_grant got=%h/%h exp=4/0010", grant, m_paddr); end
    checks++; if (s_pready !== 4'b0) begin failures++; $display("FAIL read_setup_ready got=%h exp=0", s_pready); end
    step();
    checks++; if (m_penable !== 1'b1 || s_pready !== 4'b0100) begin failures++; $display("FAIL read_access got=%b/%h exp=1/4", m_penable, s_pready); end
    checks++; if (s_prdata !== 64'h0000_1234_0000_0000) begin failures++; $display("FAIL read_data got=%h exp=0000123400000000", s_prdata); end
    drop(2);
    step();
    checks++; if (grant !== 4'b0 || m_paddr !== 16'h0 || m_psel !== 2'b0) begin failures++; $display("FAIL read_idle got=%h/%h/%b exp=0", grant, m_paddr, m_psel); end
  endtask

  task automatic test_contention();
    int order [4];
    int waited;
    order = '{0, 1, 3, 0};
    reset = 1'b1;
    step();
    reset = 1'b0;
    req(0, 16'h0100, 1'b0, 16'h0);
    req(1, 16'h0101, 1'b0, 16'h0);
    req(3, 16'h0103, 1'b0, 16'h0);
    for (int t = 0; t < 4; t++) begin
      waited = 0;
      while (grant === 4'b0 && waited < 8) begin
        step();
        waited++;
      end
      checks++; if (grant !== 4'(1 << order[t])) begin failures++; $display("FAIL cont_grant%0d got=%h exp=%h", t, grant, 4'(1 << order[t])); end
      checks++; if (m_paddr !== 16'h0100 + 16'(order[t])) begin failures++; $display("FAIL cont_addr%0d got=%h exp=%h", t, m_paddr, 16'h0100 + 16'(order[t])); end
      step();
      checks++; if (s_pready !== 4'(1 << order[t])) begin failures++; $display("FAIL cont_ready%0d got=%h exp=%h", t, s_pready, 4'(1 << order[t])); end
      if (order[t] != 0 || t == 3) drop(order[t]);
      step();
      checks++; if (grant !== 4'b0) begin failures++; $display("FAIL cont_gap%0d got=%h exp=0", t, grant); end
    end
  endtask

  task automatic test_periph_write();
    wait_cfg[1] = 2;
    req(1, 16'h8004, 1'b1, 16'hBEEF);
    step();
    checks++; if (m_psel !== 2'b10 || m_penable !== 1'b0) begin failures++; $display("FAIL wr_setup got=%b/%b exp=10/0", m_psel, m_penable); end
    checks++; if (m_pwrite !== 1'b1 || m_pwdata !== 16'hBEEF) begin failures++; $display("FAIL wr_data got=%b/%h exp=1/BEEF", m_pwrite, m_pwdata); end
    step();
    checks++; if (s_pready !== 4'b0 || m_psel !== 2'b10) begin failures++; $display("FAIL wr_wait1 got=%h/%b exp=0/10", s_pready, m_psel); end
    step();
    checks++; if (s_pready !== 4'b0) begin failures++; $display("FAIL wr_wait2 got=%h exp=0", s_pready); end
    step();
    checks++; if (s_pready !== 4'b0010 || m_pwdata !== 16'hBEEF) begin failures++; $display("FAIL wr_done got=%h/%h exp=2/BEEF", s_pready, m_pwdata); end
    drop(1);
    step();
    wait_cfg[1] = 0;
  endtask

  task automatic test_timeout();
    stuck[0] = 1'b1;
    req(3, 16'h0020, 1'b0, 16'h0);
    step();
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (s_pready !== 4'b0 || bus_timeout !== 1'b0) begin failures++; $display("FAIL tmo_wait%0d got=%h/%b exp=0/0", k, s_pready, bus_timeout); end
    end
    step();
    checks++; if (s_pready !== 4'b1000 || s_prdata !== 64'h0) begin failures++; $display("FAIL tmo_abort got=%h/%h exp=8/0", s_pready, s_prdata); end
    checks++; if (bus_timeout !== 1'b1) begin failures++; $display("FAIL tmo_pulse got=%b exp=1", bus_timeout); end
    drop(3);
    step();
    checks++; if (bus_timeout !== 1'b0 || m_psel !== 2'b0 || m_penable !== 1'b0 || grant !== 4'b0) begin
      failures++; $display("FAIL tmo_idle got=%b/%b/%b/%h exp=0", bus_timeout, m_psel, m_penable, grant);
    end
    stuck[0] = 1'b0;
  endtask

  task automatic test_timeout_race();
    wait_cfg[0] = 3;
    req(2, 16'h0040, 1'b0, 16'h0);
    step();
    step();
    step();
    step();
    checks++; if (s_pready !== 4'b0) begin failures++; $display("FAIL race_wait got=%h exp=0", s_pready); end
    step();
    checks++; if (s_pready !== 4'b0100 || bus_timeout !== 1'b0) begin failures++; $display("FAIL race_done got=%h/%b exp=4/0", s_pready, bus_timeout); end
    checks++; if (s_prdata[47:32] !== 16'h1234) begin failures++; $display("FAIL race_data got=%h exp=1234", s_prdata[47:32]); end
    drop(2);
    step();
    wait_cfg[0] = 0;
  endtask

  task automatic test_withdraw();
    stuck[0] = 1'b1;
    req(1, 16'h0050, 1'b0, 16'h0);
    step();
    step();
    drop(1);
    #1;
    checks++; if (s_pready !== 4'b0 || bus_timeout !== 1'b0) begin failures++; $display("FAIL wd_noresp got=%h/%b exp=0/0", s_pready, bus_timeout); end
    step();
    checks++; if (grant !== 4'b0 || m_psel !== 2'b0) begin failures++; $display("FAIL wd_idle got=%h/%b exp=0/0", grant, m_psel); end
    step();
    checks++; if (grant !== 4'b0 || bus_timeout !== 1'b0) begin failures++; $display("FAIL wd_stay got=%h/%b exp=0/0", grant, bus_timeout); end
    stuck[0] = 1'b0;
  endtask

  task automatic test_decode_err();
    d_paddr[15:0] = 16'hC000;
    d_psel[0]     = 1'b1;
    step();
    checks++; if (d_m_psel !== 3'b0 || d_grant !== 4'b0001) begin failures++; $display("FAIL dec_setup got=%b/%h exp=000/1", d_m_psel, d_grant); end
    step();
    checks++; if (d_m_psel !== 3'b0 || d_pready !== 4'b0001) begin failures++; $display("FAIL dec_access got=%b/%h exp=000/1", d_m_psel, d_pready); end
    checks++; if (d_prdata !== 64'h0) begin failures++; $display("FAIL dec_data got=%h exp=0", d_prdata); end
    d_psel[0] = 1'b0;
    step();
    d_paddr[31:16] = 16'h8000;
    d_psel[1]      = 1'b1;
    step();
    checks++; if (d_m_psel !== 3'b100 || d_grant !== 4'b0010) begin failures++; $display("FAIL dec_slave2 got=%b/%h exp=100/2", d_m_psel, d_grant); end
    step();
    checks++; if (d_pready !== 4'b0010 || d_prdata !== 64'h0000_0000_3333_0000) begin failures++; $display("FAIL dec_slave2_data got=%h/%h exp=2/33330000", d_pready, d_prdata); end
    d_psel[1] = 1'b0;
    step();
  endtask

  task automatic test_reset_in_access();
    stuck[0] = 1'b1;
    req(0, 16'h0060, 1'b0, 16'h0);
    step();
    step();
    checks++; if (m_penable !== 1'b1 || grant !== 4'b0001) begin failures++; $display("FAIL rst_pre got=%b/%h exp=1/1", m_penable, grant); end
    reset = 1'b1;
    step();
    checks++; if (grant !== 4'b0 || m_psel !== 2'b0 || m_penable !== 1'b0 || m_paddr !== 16'h0) begin
      failures++; $display("FAIL rst_bus got=%h/%b/%b/%h exp=0", grant, m_psel, m_penable, m_paddr);
    end
    checks++; if (s_pready !== 4'b0 || s_prdata !== 64'h0 || bus_timeout !== 1'b0) begin failures++; $display("FAIL rst_resp got=%h/%h/%b exp=0", s_pready, s_prdata, bus_timeout); end
    reset = 1'b0;
    stuck[0] = 1'b0;
    req(1, 16'h0061, 1'b0, 16'h0);
    step();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rst_rr0 got=%h exp=1", grant); end
    step();
    checks++; if (s_pready !== 4'b0001) begin failures++; $display("FAIL rst_done0 got=%h exp=1", s_pready); end
    drop(0);
    step();
    step();
    checks++; if (grant !== 4'b0010 || m_paddr !== 16'h0061) begin failures++; $display("FAIL rst_rr1 got=%h/%h exp=2/0061", grant, m_paddr); end
    step();
    drop(1);
    step();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    s_paddr     = '0;
    s_pwdata    = '0;
    s_pwrite    = '0;
    s_psel      = '0;
    s_penable   = '0;
    d_paddr     = '0;
    d_pwdata    = '0;
    d_pwrite    = '0;
    d_psel      = '0;
    d_penable   = '0;
    wait_cfg[0] = 0;
    wait_cfg[1] = 0;
    stuck[0]    = 1'b0;
    stuck[1]    = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_contention();
    test_periph_write();
    test_timeout();
    test_timeout_race();
    test_withdraw();
    test_decode_err();
    test_reset_in_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_rr_arbiter.md
# apb_rr_arbiter

Round-robin APB arbiter and slave decoder for the SoC-level data-memory interconnect. It shares the single SoC APB bus between the cluster master ports and routes each granted transfer to one of the SoC slaves (shared BRAM, peripheral block). A per-transfer timeout watchdog drives the SoC bus-reset request.

## Interface
- MASTERS, 4: number of cluster master ports.
- SLAVES, 2: number of slave ports.
- BUS_WIDTH, 16: APB address width.
- DATA_WIDTH, 16: APB data width.
- TIMEOUT, 255: maximum ACCESS cycles without PREADY before abort. Must be ≥1.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- S_PADDR  in  MASTERS*BUS_WIDTH  per-master address; master m uses slice [m*BUS_WIDTH +: BUS_WIDTH]. The same slicing applies to every other per-master bus.
- S_PWRITE, S_PSELx, S_PENABLE  in  MASTERS each  per-master APB controls.
- S_PWDATA  in  MASTERS*DATA_WIDTH  per-master write data.
- S_PRDATA  out  MASTERS*DATA_WIDTH  per-master read data.
- S_PREADY  out  MASTERS  per-master completion.
- M_PADDR  out  BUS_WIDTH  shared slave address.
- M_PWRITE, M_PENABLE  out  1  shared slave controls.
- M_PWDATA  out  DATA_WIDTH  shared slave write data.
- M_PSELx  out  SLAVES  one-hot slave select.
- M_PRDATA  in  SLAVES*DATA_WIDTH  per-slave read data.
- M_PREADY  in  SLAVES  per-slave ready.
- grant  out  MASTERS  one-hot current owner; all zero in IDLE.
- bus_timeout  out  1  one-cycle pulse on watchdog abort.

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS. Registers: state, grant index, slave index, RR pointer, timeout counter (clog2(TIMEOUT+1) bits).
- IDLE: if any S_PSELx is high, grant the first requesting master at or after the RR pointer, scanning upward modulo MASTERS. Latch the grant index and the slave index, then go to SETUP. The RR pointer becomes (granted index + 1) mod MASTERS.
- Slave decode: slave index = M_PADDR[BUS_WIDTH-1 -: SB], where SB = clog2(SLAVES). SB is 1 when SLAVES = 1; in that case the index is forced to 0. An index ≥ SLAVES is a decode error.
- SETUP: drive M_PSELx[slave]=1 and M_PENABLE=0. Go to ACCESS. On a decode error, drive no M_PSELx bit.
- ACCESS: drive M_PSELx[slave]=1 and M_PENABLE=1.
  - When M_PREADY[slave] is high: S_PREADY[grant]=1 and S_PRDATA[grant]=M_PRDATA[slave] in that same cycle, then go to IDLE.
  - Decode error: complete in the first ACCESS cycle with S_PRDATA=0 and no slave access.
- Timeout: the counter clears on entry to ACCESS and increments on each ACCESS cycle without PREADY. On the cycle it would reach TIMEOUT:
  - assert S_PREADY[grant]=1 with S_PRDATA=0;
  - pulse bus_timeout=1;
  - deassert M_PSELx/M_PENABLE on the next edge and go to IDLE.
- Withdrawal: if the granted master drops S_PSELx during SETUP or ACCESS (an APB violation), return to IDLE on the next edge. No S_PREADY is given and there is no timeout pulse.
- Muxing during SETUP and ACCESS: M_PADDR, M_PWRITE and M_PWDATA are the granted master's inputs. In IDLE they are 0.
- S_PRDATA and S_PREADY for non-granted masters are always 0.
- The master's own S_PENABLE is ignored; phases are generated by the arbiter.

## Timing
- Reset (held ≥1 cycle):
  - state=IDLE, RR pointer=0, counter=0.
  - All outputs are 0: M_PSELx, M_PENABLE, M_PADDR, M_PWDATA, M_PWRITE, S_PREADY, S_PRDATA, grant and bus_timeout.
  - Reset during SETUP or ACCESS aborts the transfer with no S_PREADY.
- Latency: a request sampled in IDLE at edge N gives SETUP in cycle N+1 and ACCESS in N+2. With a zero-wait slave, S_PREADY is high in N+2, so the minimum is 3 cycles from request to completion.
- Each wait state adds 1 cycle.
- At least one IDLE cycle occurs between transfers, so the maximum throughput is 1 transfer per 3 cycles.
- The master must drop S_PSELx or present a new transfer on the edge after S_PREADY. A held S_PSELx is treated as a new request and re-arbitrated fairly.
- Simultaneous requests in IDLE are resolved by the RR pointer only; arrival order has no effect.
- Fairness: with MASTERS masters continuously requesting, each master waits at most MASTERS-1 transfers.
- Abort: when PREADY is still low, the timeout abort happens in ACCESS cycle TIMEOUT, i.e. cycle N+1+TIMEOUT.
- PREADY arriving in the same cycle as the timeout takes priority as a normal completion, with no bus_timeout pulse.

## Test plan
- Single read, master 2 reads 0x0010, BRAM zero-wait returning 0x1234:
  - cycle N+1: M_PSELx=01, M_PENABLE=0;
  - cycle N+2: M_PENABLE=1, S_PREADY[2]=1, S_PRDATA[2]=0x1234, others 0.
- Contention, masters 0, 1 and 3 requesting together from reset: grants in order 0, 1, 3. Master 0 re-requests immediately and is served after 3, with grant one-hot each time.
- Peripheral write to 0x8004 (top bit set, SLAVES=2), with 2 wait states:
  - M_PSELx=10 and M_PWDATA equal to the master data during the transfer;
  - S_PREADY 5 cycles after the request.
- Timeout with TIMEOUT=4 and M_PREADY stuck low:
  - S_PREADY=1 and S_PRDATA=0 in the 4th ACCESS cycle, with bus_timeout high for exactly that cycle;
  - the FSM then returns to IDLE.
- Decode error with SLAVES=3 and address 0xC000: no M_PSELx bit is set, and S_PREADY=1 with data 0 in cycle N+2.
- Reset asserted in ACCESS: all outputs are 0 on the next cycle and the RR pointer is 0. The following simultaneous request from masters 1 and 0 grants 0 first.
